// File: rtl/psone_poller.sv
// rtl/psone_poller.sv - round-robin PlayStation pad poller over a bit-banged SPI link
// Frames 0x01 0x42 0x00.. to each pad in turn, collects the reply, and publishes frames carrying the 0x5A marker.
module psone_poller #(
   parameter int HALF_PER  = 100,
   parameter int NUM_PADS  = 2,
   parameter int NUM_BYTES = 5,
   parameter int ACK_TO    = 2000,
   parameter int GAP_CYC   = 50000
) (
   input  logic                   iCLK,
   input  logic                   iRESET,
   input  logic                   iEN,
   output logic [NUM_PADS-1:0]    oCS,
   output logic                   oCLK,
   output logic                   oMOSI,
   input  logic                   iMISO,
   input  logic                   iACK,
   output logic [8*NUM_BYTES-1:0] oDATA,
   output logic [1:0]             oPAD,
   output logic                   oVALID,
   output logic                   oTIMEOUT,
   output logic                   oERR,
   output logic                   oBUSY
);
   localparam int MAXC = (HALF_PER > ACK_TO) ? ((HALF_PER > GAP_CYC) ? HALF_PER : GAP_CYC)
                                             : ((ACK_TO > GAP_CYC) ? ACK_TO : GAP_CYC);
   localparam int CW = $clog2(MAXC + 1);
   localparam int BW = $clog2(NUM_BYTES);
   localparam logic [CW-1:0] HP_LAST   = CW'(HALF_PER - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TO - 1);
   // GAP is left one cycle early: the IDLE cycle that follows completes the CS-high span.
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 2);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_ACK, HOLD, GAP} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]             cnt_q, cnt_d;
   logic [3:0]                tog_q, tog_d;
   logic [BW-1:0]             byte_q, byte_d;
   logic                      ack_seen_q, ack_seen_d;
   logic [1:0]                pad_q, pad_d;
   logic [NUM_BYTES-1:0][7:0] rx_q, rx_d;
   logic [NUM_PADS-1:0]       cs_q, cs_d;
   logic                      sclk_q, sclk_d, mosi_q, mosi_d;
   logic [8*NUM_BYTES-1:0]    data_q, data_d;
   logic [1:0]                opad_q, opad_d;
   logic                      valid_q, valid_d, tmo_q, tmo_d, err_q, err_d;
   logic [1:0]                miso_sync_q, miso_sync_d, ack_sync_q, ack_sync_d;
   logic                      ack_prev_q, ack_prev_d;
   logic                      miso_s, ack_fall, hp_done, to_done, gap_done, tog_last, good;
   logic [7:0]                cmd;

   assign miso_s   = miso_sync_q[1];
   assign ack_fall = ack_prev_q & ~ack_sync_q[1];
   assign hp_done  = (cnt_q == HP_LAST);
   assign to_done  = (cnt_q == TO_LAST);
   assign gap_done = (cnt_q == GAP_LAST);
   assign tog_last = (tog_q == 4'd15);
   assign good     = (rx_q[2] == 8'h5A);
   assign cmd      = (byte_q == '0) ? 8'h01 : (byte_q == BW'(1)) ? 8'h42 : 8'h00;

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (iEN) state_d = SETUP;
         SETUP:    if (hp_done) state_d = SHIFT;
         SHIFT:    if (hp_done && tog_last) state_d = (byte_q == LAST_BYTE) ? HOLD : WAIT_ACK;
         WAIT_ACK: begin
            if (ack_seen_q) begin
               if (hp_done) state_d = SHIFT;
            end else if (!ack_fall && to_done) begin
               state_d = GAP;
            end
         end
         HOLD:     if (hp_done) state_d = GAP;
         GAP:      if (gap_done) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      tog_d       = tog_q;
      byte_d      = byte_q;
      ack_seen_d  = ack_seen_q;
      pad_d       = pad_q;
      rx_d        = rx_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      data_d      = data_q;
      opad_d      = opad_q;
      valid_d     = 1'b0;
      tmo_d       = 1'b0;
      err_d       = 1'b0;
      miso_sync_d = {miso_sync_q[0], iMISO};
      ack_sync_d  = {ack_sync_q[0], iACK};
      ack_prev_d  = ack_sync_q[1];
      case (state_q)
         IDLE: begin
            if (iEN) begin
               for (int i = 0; i < NUM_PADS; i++) cs_d[i] = (pad_q != 2'(i));
               mosi_d = 1'b0;
               byte_d = '0;
               rx_d   = '0;
               cnt_d  = '0;
            end
         end
         SETUP: begin
            if (hp_done) begin
               sclk_d = 1'b0;
               mosi_d = cmd[0];
               tog_d  = 4'd1;
               cnt_d  = '0;
            end
         end
         SHIFT: begin
            if (hp_done) begin
               cnt_d = '0;
               if (tog_q[0]) begin
                  sclk_d = 1'b1;
                  rx_d[byte_q][tog_q[3:1]] = miso_s;
                  if (tog_last) begin
                     ack_seen_d = 1'b0;
                     if (byte_q != LAST_BYTE) byte_d = byte_q + 1'b1;
                  end
               end else begin
                  sclk_d = 1'b0;
                  mosi_d = cmd[tog_q[3:1]];
               end
               if (!tog_last) tog_d = tog_q + 1'b1;
            end
         end
         WAIT_ACK: begin
            if (ack_seen_q) begin
               if (hp_done) begin
                  sclk_d = 1'b0;
                  mosi_d = cmd[0];
                  tog_d  = 4'd1;
                  cnt_d  = '0;
               end
            end else if (ack_fall) begin
               ack_seen_d = 1'b1;
               cnt_d      = '0;
            end else if (to_done) begin
               cs_d   = '1;
               sclk_d = 1'b1;
               mosi_d = 1'b0;
               tmo_d  = 1'b1;
               cnt_d  = '0;
            end
         end
         HOLD: begin
            if (hp_done) begin
               cs_d   = '1;
               mosi_d = 1'b0;
               cnt_d  = '0;
               if (good) begin
                  data_d  = rx_q;
                  opad_d  = pad_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_done) begin
               pad_d = (pad_q == 2'(NUM_PADS - 1)) ? 2'd0 : pad_q + 1'b1;
               cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         cnt_q       <= '0;
         tog_q       <= '0;
         byte_q      <= '0;
         ack_seen_q  <= 1'b0;
         pad_q       <= '0;
         rx_q        <= '0;
         cs_q        <= '1;
         sclk_q      <= 1'b1;
         mosi_q      <= 1'b0;
         data_q      <= '0;
         opad_q      <= '0;
         valid_q     <= 1'b0;
         tmo_q       <= 1'b0;
         err_q       <= 1'b0;
         miso_sync_q <= '0;
         ack_sync_q  <= 2'b11;
         ack_prev_q  <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         tog_q       <= tog_d;
         byte_q      <= byte_d;
         ack_seen_q  <= ack_seen_d;
         pad_q       <= pad_d;
         rx_q        <= rx_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         data_q      <= data_d;
         opad_q      <= opad_d;
         valid_q     <= valid_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         miso_sync_q <= miso_sync_d;
         ack_sync_q  <= ack_sync_d;
         ack_prev_q  <= ack_prev_d;
      end
   end

   assign oCS      = cs_q;
   assign oCLK     = sclk_q;
   assign oMOSI    = mosi_q;
   assign oDATA    = data_q;
   assign oPAD     = opad_q;
   assign oVALID   = valid_q;
   assign oTIMEOUT = tmo_q;
   assign oERR     = err_q;
   assign oBUSY    = |(~cs_q);
endmodule

// File: tb/tb_psone_poller.sv
// tb/tb_psone_poller.sv - scoreboard bench for psone_poller with a behavioural pad model
module tb_psone_poller;
   localparam int HP = 4, NP = 2, NB = 5, TO = 100, GAP = 20;

   logic            iCLK, iRESET, iEN, iMISO, iACK;
   logic [NP-1:0]   oCS;
   logic            oCLK, oMOSI, oVALID, oTIMEOUT, oERR, oBUSY;
   logic [8*NB-1:0] oDATA;
   logic [1:0]      oPAD;

   psone_poller #(.HALF_PER(HP), .NUM_PADS(NP), .NUM_BYTES(NB), .ACK_TO(TO), .GAP_CYC(GAP)) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .oCS(oCS), .oCLK(oCLK), .oMOSI(oMOSI),
      .iMISO(iMISO), .iACK(iACK), .oDATA(oDATA), .oPAD(oPAD), .oVALID(oVALID),
      .oTIMEOUT(oTIMEOUT), .oERR(oERR), .oBUSY(oBUSY)
   );

   typedef struct {
      logic [NB-1:0][7:0] resp;
      int                 withhold;
      int                 pad;
   } plan_t;

   typedef struct {
      int              kind;
      logic [8*NB-1:0] data;
      logic [1:0]      pad;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];
   int    checks = 0, errors = 0, n_events = 0, cyc = 0, pad_byte = -1;
   int    model_pad = 0;
   logic [8*NB-1:0] model_data = '0;
   logic [1:0]      model_opad = '0;
   logic  pad_prev_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] cmd_byte(input int b);
      return (b == 0) ? 8'h01 : (b == 1) ? 8'h42 : 8'h00;
   endfunction

   function automatic logic [NP-1:0] cs_pattern(input int pad);
      logic [NP-1:0] v;
      v = '1;
      v[pad] = 1'b0;
      return v;
   endfunction

   initial begin
      iCLK = 0;
      forever #5 iCLK = ~iCLK;
   end

   initial forever begin
      @(posedge iCLK);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Pad model: reacts to CS/SCLK sampled on the falling system clock edge.
   task automatic wait_clk_edge(input logic lvl, output bit ok);
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge iCLK);
         if (oCS == '1) return;
         if (oCLK == lvl && pad_prev_clk != lvl) begin
            pad_prev_clk = oCLK;
            ok = 1;
            return;
         end
         pad_prev_clk = oCLK;
      end
      chk("sclk_edge_seen", ok, 1);
   endtask

   task automatic pad_frame();
      plan_t p;
      logic [7:0] mb;
      bit ok;
      int t0;
      chk("plan_available", plan_q.size() != 0, 1);
      if (plan_q.size() == 0) return;
      p = plan_q.pop_front();
      chk("cs_select", oCS, cs_pattern(p.pad));
      pad_prev_clk = oCLK;
      for (int b = 0; b < NB; b++) begin
         pad_byte = b;
         mb = '0;
         for (int k = 0; k < 8; k++) begin
            wait_clk_edge(1'b0, ok);
            if (!ok) return;
            iMISO = p.resp[b][k];
            wait_clk_edge(1'b1, ok);
            if (!ok) return;
            mb[k] = oMOSI;
         end
         chk("mosi_byte", mb, cmd_byte(b));
         chk("cs_held", oCS, cs_pattern(p.pad));
         if (b < NB - 1) begin
            if (p.withhold == b) begin
               t0 = cyc;
               for (int i = 0; i < TO + 50 && oCS != '1; i++) @(negedge iCLK);
               chk("timeout_latency", cyc - t0, TO);
               return;
            end
            repeat ($urandom_range(1, 20)) @(negedge iCLK);
            iACK = 0;
            repeat (3) @(negedge iCLK);
            iACK = 1;
         end
      end
      pad_byte = NB;
   endtask

   initial begin
      iMISO = 1;
      iACK = 1;
      pad_prev_clk = 1;
      forever begin
         @(negedge iCLK);
         if (iRESET === 1'b1 && oCS != '1) begin
            pad_frame();
            for (int i = 0; i < 500 && oCS != '1; i++) @(negedge iCLK);
         end
      end
   end

   // Scoreboard monitor plus always-true output relations.
   initial begin
      exp_t e;
      forever begin
         @(negedge iCLK);
         if (oVALID || oTIMEOUT || oERR) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {oVALID, oTIMEOUT, oERR}, 3'b000);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", {oVALID, oTIMEOUT, oERR},
                   (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001);
               chk("odata", oDATA, e.data);
               chk("opad", oPAD, e.pad);
            end
            n_events++;
         end
         chk("cs_one_hot", $countones(~oCS) <= 1, 1);
         chk("busy_vs_cs", oBUSY, oCS != '1);
      end
   end

   // CS-high to next CS-low spacing while iEN stays high.
   initial begin
      bit armed, en_held, hi_prev, hi;
      int t_rise;
      armed = 0; en_held = 0; hi_prev = 1; t_rise = 0;
      forever begin
         @(negedge iCLK);
         hi = (oCS == '1);
         if (iRESET !== 1'b1) begin
            armed = 0;
         end else begin
            if (!iEN) en_held = 0;
            if (hi && !hi_prev) begin
               t_rise = cyc;
               armed = 1;
               en_held = iEN;
            end else if (!hi && hi_prev && armed) begin
               if (en_held) chk("gap_length", cyc - t_rise, GAP);
               armed = 0;
            end
         end
         hi_prev = hi;
      end
   end

   task automatic push_frame(input logic [NB-1:0][7:0] resp, input int withhold, input bit expect_out);
      plan_t p;
      exp_t e;
      p.resp = resp;
      p.withhold = withhold;
      p.pad = model_pad;
      plan_q.push_back(p);
      if (!expect_out) return;
      e.data = model_data;
      e.pad = model_opad;
      if (withhold >= 0) begin
         e.kind = 1;
      end else if (resp[2] != 8'h5A) begin
         e.kind = 2;
      end else begin
         e.kind = 0;
         model_data = resp;
         model_opad = 2'(model_pad);
         e.data = model_data;
         e.pad = model_opad;
      end
      model_pad = (model_pad + 1) % NP;
      exp_q.push_back(e);
   endtask

   task automatic wait_event(input string name);
      int s, c;
      s = n_events;
      c = 0;
      while (n_events == s && c < 3000) begin
         @(negedge iCLK);
         c++;
      end
      chk(name, n_events != s, 1);
   endtask

   function automatic logic [NB-1:0][7:0] rand_resp(input bit marker_ok);
      logic [NB-1:0][7:0] r;
      for (int i = 0; i < NB; i++) r[i] = 8'($urandom_range(0, 255));
      if (marker_ok) r[2] = 8'h5A;
      else if (r[2] == 8'h5A) r[2] = 8'h00;
      return r;
   endfunction

   initial begin
      logic [NB-1:0][7:0] r;
      int k;
      iRESET = 0;
      iEN = 0;
      repeat (3) @(negedge iCLK);
      chk("rst_cs", oCS, 2'b11);
      chk("rst_clk", oCLK, 1);
      chk("rst_mosi", oMOSI, 0);
      chk("rst_data", oDATA, 0);
      chk("rst_pad", oPAD, 0);
      chk("rst_pulses", {oVALID, oTIMEOUT, oERR}, 3'b000);
      chk("rst_busy", oBUSY, 0);
      iRESET = 1;

      r = 40'hBD7E5A41FF;
      push_frame(r, -1, 1);
      iEN = 1;
      wait_event("good_frame");
      chk("good_data_literal", oDATA, 40'hBD7E5A41FF);
      for (int i = 0; i < 2; i++) begin
         push_frame(rand_resp(1), -1, 1);
         wait_event("round_robin");
      end

      push_frame(rand_resp(1), 1, 1);
      wait_event("timeout_frame");
      r = rand_resp(1);
      r[2] = 8'h00;
      push_frame(r, -1, 1);
      wait_event("bad_marker");

      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(0, 9);
         if (k < 6) push_frame(rand_resp(1), -1, 1);
         else if (k < 8) push_frame(rand_resp(0), -1, 1);
         else push_frame(rand_resp(1), $urandom_range(0, NB - 2), 1);
         wait_event("random_frame");
      end

      pad_byte = -1;
      push_frame(rand_resp(1), -1, 1);
      for (int i = 0; i < 3000 && pad_byte != 2; i++) @(negedge iCLK);
      chk("reach_byte2", pad_byte, 2);
      iEN = 0;
      wait_event("en_drop_frame");
      repeat (GAP + 40) @(negedge iCLK);
      chk("en_drop_cs_idle", oCS, 2'b11);
      chk("en_drop_busy", oBUSY, 0);

      pad_byte = -1;
      push_frame(rand_resp(1), -1, 0);
      iEN = 1;
      for (int i = 0; i < 3000 && pad_byte != 1; i++) @(negedge iCLK);
      chk("reach_byte1", pad_byte, 1);
      repeat (10) @(negedge iCLK);
      #1 iRESET = 0;
      #1;
      chk("midrst_cs", oCS, 2'b11);
      chk("midrst_clk", oCLK, 1);
      chk("midrst_pulses", {oVALID, oTIMEOUT, oERR}, 3'b000);
      chk("midrst_busy", oBUSY, 0);
      model_pad = 0;
      model_data = '0;
      model_opad = '0;
      repeat (3) @(negedge iCLK);
      chk("midrst_data", oDATA, 0);
      push_frame(rand_resp(1), -1, 1);
      iRESET = 1;
      wait_event("post_reset_frame");
      iEN = 0;
      repeat (GAP + 40) @(negedge iCLK);
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("plan_queue_drained", plan_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/psone_poller.md
PSONE_POLLER -- requirements
Module: psone_poller

Interface
REQ-001 The block SHALL have these parameters:
- HALF_PER, default 100: iCLK cycles per SPI half-period, minimum 2.
- NUM_PADS, default 2: number of pads, each with its own chip select, range 1..4.
- NUM_BYTES, default 5: bytes per frame, range 3..9.
- ACK_TO, default 2000: iCLK cycles to wait for ACK before abort.
- GAP_CYC, default 50000: iCLK cycles from CS high to the next CS low.
REQ-002 The block SHALL have these ports, clock and reset first:
- iCLK  in  1  system clock.
- iRESET  in  1  reset; one clock; reset is asynchronous and active-low.
- iEN  in  1  level; 1 = poll continuously.
- oCS  out  NUM_PADS  chip selects, active-low, one-hot-low.
- oCLK  out  1  SPI clock, idles high.
- oMOSI  out  1  command data, LSB first.
- iMISO  in  1  pad data, asynchronous.
- iACK  in  1  pad ACK, active-low, shared, asynchronous.
- oDATA  out  8*NUM_BYTES  last good frame; byte0 in bits [7:0].
- oPAD  out  2  pad index of oDATA.
- oVALID  out  1  one-cycle pulse when oDATA/oPAD update.
- oTIMEOUT  out  1  one-cycle pulse on ACK abort.
- oERR  out  1  one-cycle pulse on bad 0x5A marker.
- oBUSY  out  1  high from CS low to CS high.

Function
REQ-003 iMISO and iACK SHALL each pass a 2-flop synchronizer; ACK detection uses a falling edge of the synchronized iACK.
REQ-004 The state machine SHALL have the states IDLE, SETUP, SHIFT, WAIT_ACK, HOLD, GAP.
REQ-005 IDLE: when iEN=1, enter SETUP; drive oCS[pad]=0 and oMOSI=0 in the entry cycle.
REQ-006 SETUP SHALL last HALF_PER cycles, then enter SHIFT.
REQ-007 SHIFT SHALL toggle oCLK every HALF_PER cycles for 16 toggles (8 falling edges, 8 rising edges).
- On falling edge k, oMOSI takes command bit k.
- On rising edge k, capture synchronized MISO bit k into rx bit k.
REQ-008 Command bytes SHALL be: byte0=0x01, byte1=0x42, all later bytes=0x00.
REQ-009 After the 8th rising edge, a byte that is not the last SHALL enter WAIT_ACK; the last byte SHALL enter HOLD.
REQ-010 WAIT_ACK:
- On an ACK falling edge, wait HALF_PER cycles, then start the next byte's first falling edge.
- If ACK_TO cycles pass without an edge, enter the abort path.
REQ-011 Abort path:
- All oCS go high and oCLK=1 in the same cycle.
- oTIMEOUT pulses in that cycle.
- oDATA is unchanged and oVALID is not asserted.
- Enter GAP.
REQ-012 HOLD SHALL last HALF_PER cycles, then raise oCS.
- If rx byte2 == 0x5A: load oDATA, load oPAD, pulse oVALID in that cycle.
- Otherwise: pulse oERR and leave oDATA unchanged.
- Enter GAP.
REQ-013 GAP SHALL count GAP_CYC cycles, then advance the pad index (wraps NUM_PADS-1 -> 0) and go to IDLE.
- The pad index also advances after an abort.
REQ-014 iEN dropping mid-frame SHALL NOT cut the frame short: the frame completes, GAP runs, then the block stays in IDLE.
REQ-015 An ACK edge outside WAIT_ACK SHALL be ignored.
REQ-016 No more than one oCS bit SHALL be low at any time.
REQ-017 oBUSY SHALL equal the OR of the inverted oCS bits.
REQ-018 The ACK timeout counter SHALL restart on every entry to WAIT_ACK.
REQ-019 The data counters SHALL saturate and never wrap inside a frame.

Reset
REQ-020 While iRESET=0, and asynchronously on its assertion, outputs SHALL be:
- oCS all 1, oCLK=1, oMOSI=0.
- oDATA=0, oPAD=0.
- oVALID=0, oTIMEOUT=0, oERR=0, oBUSY=0.
REQ-021 Reset SHALL clear the pad index to 0 and the state to IDLE.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse outputs asserted.
REQ-023 After reset release, the first frame SHALL go to pad 0.

Verification
(Bench parameters for all scenarios: HALF_PER=4, NUM_PADS=2, NUM_BYTES=5, ACK_TO=100, GAP_CYC=20.)
REQ-024 Good frame:
- Stimulus: iEN=1; pad model ACKs after bytes 0-3 and returns FF 41 5A 7E BD.
- Response: MOSI bytes decode to 01 42 00 00 00; oCS[0] low for the whole frame; oVALID pulses once; oDATA=0xBD7E5A41FF; oPAD=0.
REQ-025 Round-robin:
- Stimulus: iEN=1 held across three frames.
- Response: oPAD sequence 0,1,0; CS-high to next CS-low = 20 cycles each time.
REQ-026 Timeout:
- Stimulus: pad withholds ACK after byte1.
- Response: CS rises 100 cycles after entering WAIT_ACK; oTIMEOUT pulses; no oVALID; oDATA unchanged.
REQ-027 Bad marker:
- Stimulus: pad returns byte2=0x00.
- Response: oERR pulses; no oVALID; oDATA holds its previous value.
REQ-028 iEN drop:
- Stimulus: iEN=0 during byte 2.
- Response: frame completes with oVALID; after GAP, oCS stays all 1 and oBUSY=0.
REQ-029 Reset mid-frame:
- Stimulus: iRESET=0 during SHIFT.
- Response: same cycle, oCS all 1 and oCLK=1; after release, the next frame uses oCS[0].
